mc_main_control: RTL

- Moore-style main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit instruction opcode over successive cycles and drives every datapath enable and mux select.
- Generates the 2-bit ALU_Op consumed by the ALU control decoder: 00 = add, 01 = subtract/compare, 10 = decode from funct field.
- Sits between the instruction register opcode field and the datapath and ALU control.

---
 rtl/mc_main_control.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mc_main_control.sv
// mc_main_control: Moore main control FSM for the multicycle MIPS datapath.
// Walks each instruction through fetch, decode and its execution states, and
// drives every datapath enable, mux select and the 2-bit ALU_Op from the
// current state. illegal_op is a registered one-cycle flag raised on the
// FETCH that follows a DECODE of an unsupported opcode.
module mc_main_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALU_Op,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] State
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'h0,
    S_DECODE   = 4'h1,
    S_MEMADDR  = 4'h2,
    S_MEMREAD  = 4'h3,
    S_MEMWB    = 4'h4,
    S_MEMWRITE = 4'h5,
    S_EXECUTE  = 4'h6,
    S_RWB      = 4'h7,
    S_BRANCH   = 4'h8,
    S_JUMP     = 4'h9,
    S_RESET    = 4'hF
  } state_t;

  state_t state;
  state_t state_next;
  logic   decode_illegal;

  assign State = state;

  // State register and the registered illegal-opcode pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_RESET;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_next;
      illegal_op <= decode_illegal;
    end
  end

  // Next-state selection; opcode only matters in DECODE and MEMADDR.
  always_comb begin
    state_next     = S_FETCH;
    decode_illegal = 1'b0;
    case (state)
      S_RESET:  state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_next = S_MEMADDR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          default: begin
            state_next     = S_FETCH;
            decode_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADDR: begin
        // Opcode is re-checked here; anything but lw/sw abandons the access.
        if (Opcode == OP_LW)      state_next = S_MEMREAD;
        else if (Opcode == OP_SW) state_next = S_MEMWRITE;
        else                      state_next = S_FETCH;
      end
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECUTE:  state_next = S_RWB;
      S_RWB:      state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // Moore output decode: every control is a pure function of the state.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALU_Op      = 2'b00;
    PCSource    = 2'b00;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALU_Op  = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_Op      = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

endmodule
